// File: rtl/rf_port_ctrl_if.sv
// rtl/rf_port_ctrl_if.sv - requester and RFC-array signal bundle for rf_port_ctrl
interface rf_port_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
);
  logic             wr_req;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             wr_ack;
  logic             rd_req;
  logic [AW-1:0]    rd_addr1;
  logic [AW-1:0]    rd_addr2;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data1;
  logic [WIDTH-1:0] rd_data2;
  logic [DEPTH-1:0] write_en;
  logic [WIDTH-1:0] write_bit;
  logic [DEPTH-1:0] read_en1;
  logic [DEPTH-1:0] read_en2;
  logic [WIDTH-1:0] bus1;
  logic [WIDTH-1:0] bus2;
  logic             busy;

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr1, rd_addr2, bus1, bus2,
    output wr_ack, rd_valid, rd_data1, rd_data2, write_en, write_bit,
           read_en1, read_en2, busy
  );

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr1, rd_addr2, bus1, bus2,
    input  wr_ack, rd_valid, rd_data1, rd_data2, write_en, write_bit,
           read_en1, read_en2, busy
  );
endinterface

// File: rtl/rf_port_ctrl.sv
// rtl/rf_port_ctrl.sv - arbitrating write/dual-read access controller for an RFC array
module rf_port_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  rf_port_ctrl_if.slave port
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RDONE} state_t;

  state_t           state, next_state;
  logic             last_was_write;
  logic             take_wr, take_rd;
  logic [AW-1:0]    wr_addr_q, rd_addr1_q, rd_addr2_q;
  logic [WIDTH-1:0] wr_data_q, rd_data1_q, rd_data2_q;
  logic [DEPTH-1:0] wr_sel, rd_sel1, rd_sel2;

  // Out-of-range addresses decode to an all-zero row select.
  function automatic logic [DEPTH-1:0] row_sel(input logic [AW-1:0] addr);
    row_sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == AW'(i)) row_sel[i] = 1'b1;
    end
  endfunction

  assign wr_sel  = row_sel(wr_addr_q);
  assign rd_sel1 = row_sel(rd_addr1_q);
  assign rd_sel2 = row_sel(rd_addr2_q);

  always_comb begin
    next_state     = state;
    take_wr        = 1'b0;
    take_rd        = 1'b0;
    port.write_en  = '0;
    port.write_bit = '0;
    port.read_en1  = '0;
    port.read_en2  = '0;
    port.wr_ack    = 1'b0;
    port.rd_valid  = 1'b0;
    case (state)
      IDLE: begin
        // Write wins a tie unless the last op was a write, so neither side starves.
        if (port.wr_req && !(port.rd_req && last_was_write)) begin
          take_wr    = 1'b1;
          next_state = WRITE;
        end else if (port.rd_req) begin
          take_rd    = 1'b1;
          next_state = READ;
        end
      end
      WRITE: begin
        port.write_en  = wr_sel;
        port.write_bit = wr_data_q;
        port.wr_ack    = 1'b1;
        next_state     = IDLE;
      end
      READ: begin
        port.read_en1 = rd_sel1;
        port.read_en2 = rd_sel2;
        next_state    = RDONE;
      end
      RDONE: begin
        port.rd_valid = 1'b1;
        next_state    = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      last_was_write <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      rd_addr1_q     <= '0;
      rd_addr2_q     <= '0;
      rd_data1_q     <= '0;
      rd_data2_q     <= '0;
    end else begin
      state <= next_state;
      if (take_wr) begin
        wr_addr_q <= port.wr_addr;
        wr_data_q <= port.wr_data;
      end
      if (take_rd) begin
        rd_addr1_q <= port.rd_addr1;
        rd_addr2_q <= port.rd_addr2;
      end
      if (state == WRITE) last_was_write <= 1'b1;
      if (state == RDONE) last_was_write <= 1'b0;
      // A bus with no row enabled floats; mask it so it is never captured.
      if (state == READ) begin
        rd_data1_q <= port.bus1 & {WIDTH{|rd_sel1}};
        rd_data2_q <= port.bus2 & {WIDTH{|rd_sel2}};
      end
    end
  end

  assign port.rd_data1 = rd_data1_q;
  assign port.rd_data2 = rd_data2_q;
  assign port.busy     = (state != IDLE);

endmodule

// File: tb/tb_rf_port_ctrl.sv
// tb/tb_rf_port_ctrl.sv - scoreboard bench for rf_port_ctrl with a behavioural RFC array
module tb_rf_port_ctrl;
  localparam int W = 8;
  localparam int D = 6;
  localparam int A = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_port_ctrl_if #(.WIDTH(W), .DEPTH(D), .AW(A)) pif ();
  rf_port_ctrl #(.WIDTH(W), .DEPTH(D), .AW(A)) dut (.clk(clk), .rst(rst), .port(pif));

  // behavioural cell array driving the shared tristate buses
  logic [W-1:0] arr [D];
  always @(posedge clk)
    for (int i = 0; i < D; i++) if (pif.write_en[i]) arr[i] <= pif.write_bit;

  always_comb begin
    pif.bus1 = 'z;
    pif.bus2 = 'z;
    for (int i = 0; i < D; i++) begin
      if (pif.read_en1[i]) pif.bus1 = arr[i];
      if (pif.read_en2[i]) pif.bus2 = arr[i];
    end
  end

  typedef struct {
    bit           is_rd;
    logic [D-1:0] en1;
    logic [D-1:0] en2;
    logic [W-1:0] d1;
    logic [W-1:0] d2;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  logic [W-1:0] ref_mem [D];
  int           vectors = 0;
  int           miscompares = 0;
  bit           mon_on = 0;
  logic [D-1:0] prev_en1, prev_en2;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [D-1:0] exp_sel(input int a);
    exp_sel = '0;
    if (a < D) exp_sel[a] = 1'b1;
  endfunction

  task automatic push_write(input int a, input logic [W-1:0] d);
    exp_t e;
    e.is_rd = 0; e.en1 = exp_sel(a); e.en2 = '0; e.d1 = d; e.d2 = '0;
    sb.push_back(e);
    if (a < D) ref_mem[a] = d;
  endtask

  task automatic push_read(input int a1, input int a2);
    exp_t e;
    e.is_rd = 1; e.en1 = exp_sel(a1); e.en2 = exp_sel(a2);
    e.d1 = (a1 < D) ? ref_mem[a1] : '0;
    e.d2 = (a2 < D) ? ref_mem[a2] : '0;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (pif.wr_ack) begin
        if (sb.size() == 0) check_eq("sb_underflow_wr", 1, 0);
        else begin
          mon_e = sb.pop_front();
          check_eq("order_wr", 0, 32'(mon_e.is_rd));
          check_eq("write_en", 32'(pif.write_en), 32'(mon_e.en1));
          check_eq("write_bit", 32'(pif.write_bit), 32'(mon_e.d1));
        end
      end else begin
        check_eq("write_idle", {pif.write_en, pif.write_bit}, 0);
      end
      if (pif.rd_valid) begin
        if (sb.size() == 0) check_eq("sb_underflow_rd", 1, 0);
        else begin
          mon_e = sb.pop_front();
          check_eq("order_rd", 1, 32'(mon_e.is_rd));
          check_eq("read_en1", 32'(prev_en1), 32'(mon_e.en1));
          check_eq("read_en2", 32'(prev_en2), 32'(mon_e.en2));
          check_eq("read_en_rdone", {pif.read_en1, pif.read_en2}, 0);
          check_eq("rd_data1", 32'(pif.rd_data1), 32'(mon_e.d1));
          check_eq("rd_data2", 32'(pif.rd_data2), 32'(mon_e.d2));
        end
      end
    end
    prev_en1 = pif.read_en1;
    prev_en2 = pif.read_en2;
  end

  task automatic wait_ack(input string tag, output int cnt);
    cnt = 0;
    for (int i = 1; i <= 20 && cnt == 0; i++) begin
      @(negedge clk);
      if (pif.wr_ack) cnt = i;
    end
    if (cnt == 0) check_eq(tag, 0, 1);
  endtask

  task automatic wait_valid(input string tag, output int cnt);
    cnt = 0;
    for (int i = 1; i <= 20 && cnt == 0; i++) begin
      @(negedge clk);
      if (pif.rd_valid) cnt = i;
    end
    if (cnt == 0) check_eq(tag, 0, 1);
  endtask

  task automatic do_write(input int a, input logic [W-1:0] d);
    int cnt;
    @(posedge clk); #1;
    push_write(a, d);
    pif.wr_addr = A'(a);
    pif.wr_data = d;
    pif.wr_req  = 1'b1;
    wait_ack("wr_timeout", cnt);
    check_eq("wr_latency", cnt, 2);
    @(posedge clk); #1;
    pif.wr_req = 1'b0;
  endtask

  task automatic do_read(input int a1, input int a2);
    int cnt;
    logic [W-1:0] e1, e2;
    @(posedge clk); #1;
    push_read(a1, a2);
    e1 = (a1 < D) ? ref_mem[a1] : '0;
    e2 = (a2 < D) ? ref_mem[a2] : '0;
    pif.rd_addr1 = A'(a1);
    pif.rd_addr2 = A'(a2);
    pif.rd_req   = 1'b1;
    wait_valid("rd_timeout", cnt);
    check_eq("rd_latency", cnt, 3);
    @(posedge clk); #1;
    pif.rd_req = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("data_hold", {pif.rd_data1, pif.rd_data2}, {e1, e2});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst = 1'b1;
    pif.wr_req = 1'b1; pif.wr_addr = '0; pif.wr_data = '0;
    pif.rd_req = 1'b0; pif.rd_addr1 = '0; pif.rd_addr2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ctrl", {pif.wr_ack, pif.rd_valid, pif.busy}, 0);
    check_eq("rst_en", {pif.write_en, pif.read_en1, pif.read_en2}, 0);
    check_eq("rst_wbit", 32'(pif.write_bit), 0);
    check_eq("rst_data", {pif.rd_data1, pif.rd_data2}, 0);
    pif.wr_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    mon_on = 1;

    do_write(0, 8'h3C);
    do_write(3, 8'hFF);
    do_write(5, 8'hA5);
    do_read(5, 0);
    do_read(3, 3);
    do_read(7, 1);
    do_write(7, 8'h11);
    do_read(6, 5);

    // simultaneous requests: write wins after a read, then read wins after a write
    @(posedge clk); #1;
    push_write(2, 8'h5A);
    push_read(2, 0);
    push_write(4, 8'hC3);
    push_read(4, 3);
    pif.wr_addr = 3'd2; pif.wr_data = 8'h5A; pif.wr_req = 1'b1;
    pif.rd_addr1 = 3'd2; pif.rd_addr2 = 3'd0; pif.rd_req = 1'b1;
    fork
      begin
        int wc;
        wait_ack("arb_w1_timeout", wc);
        @(posedge clk); #1;
        pif.wr_addr = 3'd4; pif.wr_data = 8'hC3;
        wait_ack("arb_w2_timeout", wc);
        @(posedge clk); #1;
        pif.wr_req = 1'b0;
      end
      begin
        int rc;
        wait_valid("arb_r1_timeout", rc);
        @(posedge clk); #1;
        pif.rd_addr1 = 3'd4; pif.rd_addr2 = 3'd3;
        wait_valid("arb_r2_timeout", rc);
        @(posedge clk); #1;
        pif.rd_req = 1'b0;
      end
    join

    // reset while in READ aborts the transaction
    @(posedge clk); #1;
    pif.rd_addr1 = 3'd3; pif.rd_addr2 = 3'd3; pif.rd_req = 1'b1;
    @(posedge clk); #1;
    check_eq("busy_read", 32'(pif.busy), 1);
    check_eq("rden_read", {pif.read_en1, pif.read_en2}, {exp_sel(3), exp_sel(3)});
    rst = 1'b1; pif.rd_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("abort_ctrl", {pif.rd_valid, pif.busy}, 0);
    check_eq("abort_data", {pif.rd_data1, pif.rd_data2}, 0);
    check_eq("abort_en", {pif.read_en1, pif.read_en2}, 0);
    c = 0;
    repeat (4) begin
      @(negedge clk);
      if (pif.rd_valid) c++;
    end
    check_eq("abort_no_valid", c, 0);

    do_read(5, 2);
    check_eq("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
